// File: rtl/hvac_zone_scheduler.sv
// Round-robin heat/cool plant scheduler with hysteresis and min on/off timing.
// Optional run-length fairness limit: define HVAC_MAX_RUN_EN.
module hvac_zone_scheduler #(
  parameter int NZONES  = 4,
  parameter int TW      = 12,
  parameter int HYST    = 32,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4,
  parameter int MAX_RUN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NZONES-1:0]    zone_en,
  input  logic [NZONES*TW-1:0] setpoint,
  input  logic [NZONES*TW-1:0] temp,
  output logic                 heat,
  output logic                 cool,
  output logic                 idle,
  output logic [NZONES-1:0]    zone_grant,
  output logic [1:0]           state_o
);

  localparam int IW   = (NZONES > 1) ? $clog2(NZONES) : 1;
  localparam int RMAX = (MAX_RUN > MIN_ON) ? MAX_RUN : MIN_ON;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int OW   = $clog2(MIN_OFF + 1);
  localparam int EW   = TW + 2;

  localparam logic signed [EW-1:0] HY = EW'(HYST);
  localparam logic [RW-1:0] RUN_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HEAT = 2'b01,
    S_COOL = 2'b10,
    S_LOCK = 2'b11
  } state_e;

  logic [NZONES-1:0] heat_req;
  logic [NZONES-1:0] cool_req;
  logic [NZONES-1:0] heat_tgt;
  logic [NZONES-1:0] cool_tgt;
  logic [NZONES-1:0] any_req;

  // Widened by two bits so setpoint +/- band never wraps
  for (genvar g = 0; g < NZONES; g++) begin : g_dem
    logic signed [EW-1:0] sp_x;
    logic signed [EW-1:0] t_x;
    assign sp_x = {{2{setpoint[g*TW+TW-1]}},
                   setpoint[g*TW +: TW]};
    assign t_x  = {{2{temp[g*TW+TW-1]}},
                   temp[g*TW +: TW]};
    assign heat_req[g] = zone_en[g] & (t_x < (sp_x - HY));
    assign cool_req[g] = zone_en[g] & (t_x > (sp_x + HY));
    assign heat_tgt[g] = (t_x >= sp_x);
    assign cool_tgt[g] = (t_x <= sp_x);
  end

  assign any_req = heat_req | cool_req;

  state_e            state_q, state_d;
  logic [IW-1:0]     zone_q, zone_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [RW-1:0]     run_q, run_d;
  logic [OW-1:0]     off_q, off_d;
  logic [NZONES-1:0] grant_q, grant_d;

  logic          found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;

  // Scan from the pointer; lowest offset wins
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NZONES - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NZONES);
      if (any_req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  logic served_en;
  logic served_done;
  logic min_on_met;
  logic max_hit;

  assign served_en   = zone_en[zone_q];
  assign served_done = (state_q == S_HEAT) ? heat_tgt[zone_q]
                                           : cool_tgt[zone_q];
  assign min_on_met  = (run_q >= RW'(MIN_ON - 1));

`ifdef HVAC_MAX_RUN_EN
  logic other_req;
  assign other_req = |(any_req & ~grant_q);
  assign max_hit   = (run_q >= RW'(MAX_RUN - 1)) & other_req;
`else
  assign max_hit   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    run_d   = run_q;
    off_d   = off_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = heat_req[win_idx] ? S_HEAT : S_COOL;
          zone_d  = win_idx;
          run_d   = '0;
          grant_d = NZONES'(1) << win_idx;
        end
      end
      S_HEAT, S_COOL: begin
        if (!served_en || (min_on_met && served_done) || max_hit) begin
          state_d = S_LOCK;
          off_d   = '0;
          grant_d = '0;
          ptr_d   = (zone_q == IW'(NZONES - 1)) ? '0 : zone_q + 1'b1;
        end else if (run_q != RUN_SAT) begin
          run_d = run_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (off_q >= OW'(MIN_OFF - 1)) begin
          state_d = S_IDLE;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      zone_q  <= '0;
      ptr_q   <= '0;
      run_q   <= '0;
      off_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      off_q   <= off_d;
      grant_q <= grant_d;
    end
  end

  assign heat       = (state_q == S_HEAT);
  assign cool       = (state_q == S_COOL);
  assign idle       = ~(heat | cool);
  assign zone_grant = grant_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Bench for hvac_zone_scheduler: directed scenarios plus random traffic
// against a cycle-level behavioural model of the zone scheduler.
module tb_hvac_zone_scheduler;

  localparam int N       = 4;
  localparam int TW      = 12;
  localparam int HYST    = 32;
  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 4;
`ifdef HVAC_MAX_RUN_EN
  localparam int MAX_RUN = 16;
`else
  localparam int MAX_RUN = 64;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    zone_en;
  logic [N*TW-1:0] setpoint;
  logic [N*TW-1:0] temp;
  logic            heat;
  logic            cool;
  logic            idle;
  logic [N-1:0]    zone_grant;
  logic [1:0]      state_o;

  hvac_zone_scheduler #(
    .NZONES(N), .TW(TW), .HYST(HYST),
    .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .reset(reset), .zone_en(zone_en),
    .setpoint(setpoint), .temp(temp),
    .heat(heat), .cool(cool), .idle(idle),
    .zone_grant(zone_grant), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 heat, 2 cool, 3 lockout
  int m_mode = 0;
  int m_zone = 0;
  int m_run  = 0;
  int m_lock = 0;
  int m_ptr  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int zt(input int z);
    return int'($signed(temp[z*TW +: TW]));
  endfunction

  function automatic int zs(input int z);
    return int'($signed(setpoint[z*TW +: TW]));
  endfunction

  task automatic set_zone(input int z, input int sp, input int t);
    setpoint[z*TW +: TW] = sp[TW-1:0];
    temp[z*TW +: TW]     = t[TW-1:0];
  endtask

  function automatic void model_step();
    bit hr[N];
    bit cr[N];
    bit ex;
    bit done;
    int z;
    for (int i = 0; i < N; i++) begin
      hr[i] = zone_en[i] && (zt(i) < zs(i) - HYST);
      cr[i] = zone_en[i] && (zt(i) > zs(i) + HYST);
    end
    case (m_mode)
      0: begin
        done = 0;
        for (int k = 0; k < N; k++) begin
          z = (m_ptr + k) % N;
          if (!done && (hr[z] || cr[z])) begin
            done   = 1;
            m_mode = hr[z] ? 1 : 2;
            m_zone = z;
            m_run  = 0;
          end
        end
      end
      1, 2: begin
        ex = !zone_en[m_zone];
        if (m_run >= MIN_ON - 1) begin
          if (m_mode == 1 && zt(m_zone) >= zs(m_zone)) ex = 1;
          if (m_mode == 2 && zt(m_zone) <= zs(m_zone)) ex = 1;
        end
`ifdef HVAC_MAX_RUN_EN
        if (m_run >= MAX_RUN - 1)
          for (int i = 0; i < N; i++)
            if (i != m_zone && (hr[i] || cr[i])) ex = 1;
`endif
        if (ex) begin
          m_mode = 3;
          m_lock = 0;
          m_ptr  = (m_zone + 1) % N;
        end else begin
          m_run++;
        end
      end
      default: begin
        m_lock++;
        if (m_lock >= MIN_OFF) m_mode = 0;
      end
    endcase
  endfunction

  task automatic compare_model();
    logic [8:0] got;
    logic [8:0] exp;
    int mg;
    mg  = (m_mode == 1 || m_mode == 2) ? (1 << m_zone) : 0;
    exp = {2'(m_mode), m_mode == 1, m_mode == 2,
           (m_mode == 0 || m_mode == 3), 4'(mg)};
    got = {state_o, heat, cool, idle, zone_grant};
    chk("model", 32'(got), 32'(exp));
    chk("onehot", int'(heat) + int'(cool) + int'(idle), 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    compare_model();
  endtask

  // entered at a negedge; reset asserted in the low phase
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_hci", 32'({heat, cool, idle}), 32'(3'b001));
    chk("rst_grant", 32'(zone_grant), 0);
    m_mode = 0;
    m_ptr  = 0;
    m_run  = 0;
    m_lock = 0;
    m_zone = 0;
    @(negedge clk);
    reset = 1'b1;
    compare_model();
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (state_o != 2'b00 && n < lim) begin
      cycle();
      n++;
    end
    chk("wait_idle", 32'(state_o), 0);
  endtask

  task automatic wait_grant(input int lim);
    int n = 0;
    while (zone_grant == '0 && n < lim) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    reset   = 1'b0;
    zone_en = '1;
    setpoint = '0;
    temp     = '0;
    for (int i = 0; i < N; i++) set_zone(i, 320, 320);
    #1;
    chk("por_state", 32'(state_o), 0);
    chk("por_idle", 32'(idle), 1);
    @(negedge clk);
    reset = 1'b1;
    compare_model();

    // reset in the middle of a heat run
    set_zone(0, 320, 280);
    cycle();
    chk("t1_grant", 32'(zone_grant), 32'(4'b0001));
    cycle();
    set_zone(0, 320, 320);
    async_reset();
    cycle();
    chk("t1_idle", 32'(state_o), 0);

    // minimum on time, then lockout
    set_zone(0, 320, 280);
    cycle();
    chk("t2_grant", 32'(zone_grant), 32'(4'b0001));
    chk("t2_heat", 32'(heat), 1);
    set_zone(0, 320, 330);
    n = 0;
    while (heat === 1'b1 && n < 100) begin
      n++;
      cycle();
    end
    chk("t2_run_len", n, MIN_ON);
    n = 0;
    while (state_o == 2'b11 && n < 100) begin
      n++;
      cycle();
    end
    chk("t2_lock_len", n, MIN_OFF);
    chk("t2_back_idle", 32'(state_o), 0);

    // band edges
    set_zone(0, 320, 288);
    cycle();
    chk("t3_edge_lo", 32'(idle), 1);
    set_zone(0, 320, 287);
    cycle();
    chk("t3_heat", 32'(heat), 1);
    set_zone(0, 320, 320);
    wait_idle(40);
    set_zone(0, 320, 352);
    cycle();
    chk("t3_edge_hi", 32'(idle), 1);
    set_zone(0, 320, 353);
    cycle();
    chk("t3_cool", 32'(cool), 1);
    set_zone(0, 320, 320);
    wait_idle(40);

    // no wrap near the numeric limits
    set_zone(0, 2040, 2047);
    cycle();
    chk("t3_top", 32'(idle), 1);
    set_zone(0, -2040, -2048);
    cycle();
    chk("t3_bot", 32'(idle), 1);
    set_zone(0, 2047, -2048);
    cycle();
    chk("t3_span", 32'(heat), 1);
    set_zone(0, 320, 320);
    wait_idle(40);

    // round-robin between zones 1 and 3
    async_reset();
    set_zone(1, 320, 360);
    set_zone(3, 320, 360);
    cycle();
    chk("t4_first", 32'(zone_grant), 32'(4'b0010));
    chk("t4_cool", 32'(cool), 1);
    set_zone(1, 320, 320);
    wait_idle(40);
    wait_grant(10);
    chk("t4_second", 32'(zone_grant), 32'(4'b1000));
    set_zone(1, 320, 360);
    set_zone(3, 320, 320);
    wait_idle(40);
    wait_grant(10);
    chk("t4_third", 32'(zone_grant), 32'(4'b0010));
    set_zone(1, 320, 320);
    wait_idle(40);

    // safety exit on disable
    set_zone(0, 320, 280);
    cycle();
    chk("t5_heat", 32'(heat), 1);
    cycle();
    cycle();
    zone_en[0] = 1'b0;
    cycle();
    chk("t5_state", 32'(state_o), 32'(2'b11));
    chk("t5_grant", 32'({heat, zone_grant}), 0);
    zone_en[0] = 1'b1;
    set_zone(0, 320, 320);
    wait_idle(20);

    // unsatisfiable zone 2 with zone 0 waiting
    set_zone(2, 320, 200);
    set_zone(0, 320, 280);
    cycle();
    chk("t6_grant", 32'(zone_grant), 32'(4'b0100));
`ifdef HVAC_MAX_RUN_EN
    n = 0;
    while (zone_grant == 4'b0100 && n < 300) begin
      n++;
      cycle();
    end
    chk("t6_max_run", n, MAX_RUN);
    wait_grant(20);
    chk("t6_next", 32'(zone_grant), 32'(4'b0001));
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (zone_grant == 4'b0100) n++;
    end
    chk("t6_hold", n, 200);
`endif
    set_zone(2, 320, 320);
    set_zone(0, 320, 320);
    wait_idle(300);

    // random traffic
    for (int it = 0; it < 3000; it++) begin
      for (int z = 0; z < N; z++) begin
        if ($urandom_range(0, 199) == 0) begin
          set_zone(z, int'($urandom_range(0, 4095)) - 2048,
                   int'($urandom_range(0, 4095)) - 2048);
        end else if ($urandom_range(0, 3) == 0) begin
          d = int'($urandom_range(0, 100)) - 50;
          set_zone(z, 320, 320 + d);
        end
        if ($urandom_range(0, 99) == 0) zone_en[z] = ~zone_en[z];
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
